// File: rtl/sum_accumulator.sv
// Accumulation stage of the sum-of-N datapath: loads N, accepts N terms over valid/ready, pulses done.
// Define SUM_SIGNED_EN to treat data_in as two's complement (sign-extended); default is unsigned.
module sum_accumulator #(
  parameter  int DATA_W = 8,
  parameter  int N_W    = 4,
  localparam int SUM_W  = DATA_W + N_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [SUM_W-1:0]  sum,
  output logic [N_W-1:0]    count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SUM_W-1:0] r_sum;
  logic [N_W-1:0]   r_count;
  logic             w_beat;
  logic             w_load;

  function automatic logic [SUM_W-1:0] ext(input logic [DATA_W-1:0] d);
`ifdef SUM_SIGNED_EN
    ext = {{N_W{d[DATA_W-1]}}, d};
`else
    ext = {{N_W{1'b0}}, d};
`endif
  endfunction

  assign w_beat = (r_state == S_ACC) && data_valid;
  assign w_load = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (n_in != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        if (w_beat && (r_count == N_W'(1))) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake/status outputs come from the state register only, never from inputs.
  always_comb begin
    data_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_ACC: begin
        data_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_sum   <= '0;
      r_count <= n_in;
    end else if (w_beat) begin
      r_sum   <= r_sum + ext(data_in);
      r_count <= r_count - N_W'(1);
    end
  end

  assign sum   = r_sum;
  assign count = r_count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomised scoreboard bench for sum_accumulator; the model sums terms with plain integer arithmetic.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  n_in = '0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [11:0] sum;
  logic [3:0]  count;
  logic        busy;
  logic        done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  tq[$];
  int          gq[$];
  bit          prev_done = 1'b0;

  sum_accumulator #(.DATA_W(8), .N_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .sum(sum),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int term_val(input logic [7:0] d);
`ifdef SUM_SIGNED_EN
    return (d >= 8'd128) ? int'(d) - 256 : int'(d);
`else
    return int'(d);
`endif
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected final sum.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("final_sum", {20'd0, sum}, {20'd0, exp_q.pop_front()});
        chk("done_count", {28'd0, count}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_ready", {31'd0, data_ready}, 32'd0);
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic run_sum(input int n, input bit rnd_gaps, input bit poke, input int abort_after);
    int acc;
    int g;
    acc = 0;
    start = 1'b1;
    n_in  = n[3:0];
    if (n == 0) exp_q.push_back(12'd0);
    step();
    start = 1'b0;
    n_in  = 4'($urandom);
    chk("start_count", {28'd0, count}, n);
    chk("start_sum", {20'd0, sum}, 32'd0);
    chk("start_busy", {31'd0, busy}, {31'd0, n != 0});
    chk("start_ready", {31'd0, data_ready}, {31'd0, n != 0});
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_sum", {20'd0, sum}, 32'd0);
        chk("abort_count", {28'd0, count}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, data_ready}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        return;
      end
      g = (i < gq.size()) ? gq[i] : (rnd_gaps ? $urandom_range(0, 2) : 0);
      for (int k = 0; k < g; k++) begin
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        start      = poke;
        n_in       = 4'($urandom);
        step();
        start = 1'b0;
        chk("gap_count", {28'd0, count}, n - i);
      end
      acc += term_val(tq[i]);
      data_valid = 1'b1;
      data_in    = tq[i];
      if (i == n - 1) exp_q.push_back(12'(acc));
      step();
      data_valid = 1'b0;
      chk("beat_count", {28'd0, count}, n - 1 - i);
      chk("beat_sum", {20'd0, sum}, {20'd0, 12'(acc)});
    end
    step();
    chk("idle_hold_sum", {20'd0, sum}, {20'd0, 12'(acc)});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    data_valid = 1'b1;
    data_in    = 8'($urandom);
    step();
    data_valid = 1'b0;
    chk("idle_ignore_valid", {20'd0, sum}, {20'd0, 12'(acc)});
  endtask

  initial begin
    #1;
    chk("reset_sum", {20'd0, sum}, 32'd0);
    chk("reset_count", {28'd0, count}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, data_ready}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    step();
    rst = 1'b0;
    step();

    tq = {}; gq = {};
    for (int i = 0; i < 4; i++) tq.push_back(8'(i + 1));
    run_sum(4, 1'b0, 1'b0, -1);
`ifndef SUM_SIGNED_EN
    chk("n4_sum_10", {20'd0, sum}, 32'd10);
`endif

    run_sum(0, 1'b0, 1'b0, -1);
    chk("n0_sum", {20'd0, sum}, 32'd0);

    tq = {};
    for (int i = 0; i < 15; i++) tq.push_back(8'hFF);
    run_sum(15, 1'b0, 1'b0, -1);
`ifdef SUM_SIGNED_EN
    chk("n15_sum", {20'd0, sum}, 32'h0FF1);
`else
    chk("n15_sum", {20'd0, sum}, 32'd3825);
`endif

    tq = {}; gq = {};
    tq.push_back(8'd5); tq.push_back(8'd6); tq.push_back(8'd7);
    gq.push_back(0); gq.push_back(2); gq.push_back(1);
    run_sum(3, 1'b0, 1'b1, -1);
    chk("gapped_sum_18", {20'd0, sum}, 32'd18);
    gq = {};

    tq = {};
    for (int i = 0; i < 5; i++) tq.push_back(8'(10 + i));
    run_sum(5, 1'b0, 1'b0, 2);

    tq = {};
    tq.push_back(8'd9);
    run_sum(1, 1'b0, 1'b0, -1);
    chk("after_abort_sum_9", {20'd0, sum}, 32'd9);

    tq = {};
    for (int i = 0; i < 3; i++) tq.push_back(8'hFF);
    run_sum(3, 1'b0, 1'b0, -1);
`ifdef SUM_SIGNED_EN
    chk("ff3_sum", {20'd0, sum}, 32'h0FFD);
`else
    chk("ff3_sum", {20'd0, sum}, 32'd765);
`endif

    for (int r = 0; r < 25; r++) begin
      int n;
      n  = $urandom_range(0, 15);
      tq = {};
      for (int i = 0; i < n; i++) tq.push_back(8'($urandom));
      run_sum(n, 1'b1, 1'($urandom_range(0, 1)), -1);
    end

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Accumulation stage of the sum-of-N-numbers datapath, directly downstream of the down counter. It loads a term count N and accepts exactly N data words over a valid/ready handshake. It adds each accepted word into a widened running sum and exposes the remaining-term count for the counter-side logic. When the last term is accepted, it pulses `done` and holds the final sum until the next start.

## Interface
- `DATA_W`, 8, width of each input term.
- `N_W`, 4, width of the term count; matches the down counter's 4-bit N/out.
- SUM_W is derived as DATA_W+N_W; it is not overridable.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a new sum; sampled only in IDLE.
- `n_in`  in  N_W  number of terms; sampled with `start`.
- `data_in`  in  DATA_W  term value.
- `data_valid`  in  1  `data_in` valid this cycle.
- `data_ready`  out  1  block accepts a term this cycle.
- `sum`  out  SUM_W  running / final sum.
- `count`  out  N_W  terms still to be accepted.
- `busy`  out  1  high in ACC.
- `done`  out  1  one-cycle pulse when the sum is final.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `start`=1 and `n_in`≠0 → ACC; `count`←`n_in`, `sum`←0.
  - `start`=1 and `n_in`=0 → DONE; `sum`←0, `count`←0.
  - Otherwise hold.
- ACC:
  - `data_ready`=1. A beat is accepted when `data_valid`&`data_ready` at the rising edge.
  - On a beat: `sum`←`sum`+ext(`data_in`) and `count`←`count`−1.
  - If `count`=1 at that beat → DONE.
  - No beat → hold all state.
- DONE: `done`=1 for exactly one cycle, then unconditionally → IDLE.
- `data_ready`, `busy` and `done` are decoded from the state register only, with no combinational path from inputs.
- `start` outside IDLE is ignored; an in-progress sum is never restarted.
- `data_valid` outside ACC is ignored; no beat is consumed.
- `sum` and `count` hold their last values in IDLE. The final sum stays readable until the next accepted `start`.
- Arithmetic:
  - ext() zero-extends `data_in` to SUM_W by default.
  - SUM_W = DATA_W+N_W guarantees no overflow for up to 2^N_W−1 terms.
  - Addition wraps modulo 2^SUM_W (only reachable in signed mode, which also cannot overflow).

## Timing
- Reset values: state=IDLE, `sum`=0, `count`=0, `data_ready`=0, `busy`=0, `done`=0. Reset asserted mid-ACC aborts the operation immediately; no `done` is issued.
- `start` at edge k: `busy`/`data_ready` are high from after k. The first beat can be accepted at edge k+1.
- Last beat at edge m: `sum` is final after m, `done` is high for the cycle between m and m+1, and the block is back in IDLE after m+1.
- With `n_in`=0: `done` is high for the cycle after the `start` edge.
- Back-to-back: the earliest next `start` is sampled at edge m+2 (the first IDLE cycle).
- Throughput: one term per cycle. Latency from last beat to `done` is 0 cycles after the edge.
- The down counter updates on the falling edge. This block samples on the rising edge, so `n_in` driven from the counter is stable half a cycle before sampling.

## Configuration
- `SUM_SIGNED_EN` defined:
  - `data_in` is two's complement and is sign-extended to SUM_W.
  - `sum` is two's complement.
- `SUM_SIGNED_EN` undefined (default): `data_in` is unsigned and zero-extended.
- No other behaviour differs between the two modes.

## Test plan
- N=4, terms 1,2,3,4 on consecutive cycles → `sum`=10. `count` steps 4→3→2→1→0. `done` is high for one cycle after the 4th beat.
- N=0 with `start` → `done` is high in the next cycle, `sum`=0, and no `data_ready` cycle occurs.
- N=15, all terms 255 → `sum`=3825 (12'hEF1) with no overflow.
- N=3 with `data_valid` toggling 1,0,0,1,0,1 (terms 5,_,_,6,_,7) → only valid beats count, `sum`=18. `start` pulsed mid-ACC is ignored.
- N=5: after 2 beats, assert `rst` asynchronously between edges → all outputs go to 0 immediately, state=IDLE, no `done`. A subsequent N=1, term 9 → `sum`=9.
- N=3, terms 8'hFF ×3: without `SUM_SIGNED_EN` → `sum`=765; with `SUM_SIGNED_EN` → `sum`=12'hFFD (−3).
